// File: rtl/io_port_unit_pkg.sv
// Shared definitions for the IO port unit: default sizes, interrupt codes
// and the state types of the input-holding and interrupt FSMs.
package io_port_unit_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int OUT_DEPTH_DEF = 4;

    localparam logic [1:0] INT_NONE = 2'b00;

    // Interrupt states are encoded directly as the codes sent to the PC unit,
    // so INT_FIRST = 2'b11 and INT_SECOND = 2'b01 double as the code values.
    typedef enum logic [1:0] {
        INT_IDLE   = 2'b00,
        INT_FIRST  = 2'b11,
        INT_SECOND = 2'b01
    } int_state_t;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

endpackage

// File: rtl/io_port_unit_sync_fifo.sv
// Synchronous FIFO with head-word read port; a push into a full FIFO only
// succeeds when a pop happens on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; discarding words is done via pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/io_port_unit.sv
// Processor IO port: buffered OUT path to a device, single-word IN holding
// register, and a two-phase interrupt sequencer with one pending request.
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int OUT_DEPTH = OUT_DEPTH_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              out_en,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] in_port_data,
    input  logic              in_consume,
    input  logic              int_req,
    output logic [1:0]        interrupt_signal,
    output logic              overflow
);
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic overflow_reg;

    assign dev_out_valid = !fifo_empty;
    assign fifo_pop      = dev_out_valid && dev_out_ready;
    assign overflow      = overflow_reg;

    sync_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (DATA_W)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (out_en),
        .pop     (fifo_pop),
        .wr_data (out_data),
        .rd_data (dev_out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A word is lost only when full and nothing leaves on the same edge.
    always_ff @(posedge clk) begin
        if (reset) overflow_reg <= 1'b0;
        else if (out_en && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
    end

    in_state_t         in_state_reg;
    in_state_t         in_state_next;
    logic [DATA_W-1:0] in_data_reg;
    logic [DATA_W-1:0] in_data_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_reg <= IN_EMPTY;
            in_data_reg  <= '0;
        end else begin
            in_state_reg <= in_state_next;
            in_data_reg  <= in_data_next;
        end
    end

    always_comb begin
        in_state_next = in_state_reg;
        in_data_next  = in_data_reg;
        case (in_state_reg)
            IN_EMPTY: begin
                if (dev_in_valid) begin
                    in_state_next = IN_FULL;
                    in_data_next  = dev_in_data;
                end
            end
            IN_FULL: begin
                if (in_consume) in_state_next = IN_EMPTY;
            end
            default: in_state_next = IN_EMPTY;
        endcase
    end

    assign dev_in_ready = (in_state_reg == IN_EMPTY);
    assign in_port_data = in_data_reg;

    int_state_t int_state_reg;
    int_state_t int_state_next;
    logic       pending_reg;
    logic       pending_next;
    logic       int_req_prev_reg;
    logic       int_rise;

    assign int_rise = int_req && !int_req_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_state_reg    <= INT_IDLE;
            pending_reg      <= 1'b0;
            int_req_prev_reg <= 1'b0;
        end else begin
            int_state_reg    <= int_state_next;
            pending_reg      <= pending_next;
            int_req_prev_reg <= int_req;
        end
    end

    always_comb begin
        int_state_next = int_state_reg;
        pending_next   = pending_reg;
        case (int_state_reg)
            INT_IDLE: begin
                if (int_rise || pending_reg) begin
                    int_state_next = INT_FIRST;
                    pending_next   = 1'b0;
                end
            end
            INT_FIRST: begin
                int_state_next = INT_SECOND;
                if (int_rise) pending_next = 1'b1;
            end
            INT_SECOND: begin
                int_state_next = INT_IDLE;
                if (int_rise) pending_next = 1'b1;
            end
            default: int_state_next = INT_IDLE;
        endcase
    end

    assign interrupt_signal = int_state_reg;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed and randomized checks of io_port_unit against a queue-based
// behavioural model of the OUT FIFO, IN holding register and interrupt sequencer.
module tb_io_port_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_en;
    logic [15:0] out_data;
    logic [15:0] dev_out_data;
    logic        dev_out_valid;
    logic        dev_out_ready;
    logic [15:0] dev_in_data;
    logic        dev_in_valid;
    logic        dev_in_ready;
    logic [15:0] in_port_data;
    logic        in_consume;
    logic        int_req;
    logic [1:0]  interrupt_signal;
    logic        overflow;

    always #5 clk = ~clk;

    io_port_unit #(.OUT_DEPTH(4), .DATA_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .out_en           (out_en),
        .out_data         (out_data),
        .dev_out_data     (dev_out_data),
        .dev_out_valid    (dev_out_valid),
        .dev_out_ready    (dev_out_ready),
        .dev_in_data      (dev_in_data),
        .dev_in_valid     (dev_in_valid),
        .dev_in_ready     (dev_in_ready),
        .in_port_data     (in_port_data),
        .in_consume       (in_consume),
        .int_req          (int_req),
        .interrupt_signal (interrupt_signal),
        .overflow         (overflow)
    );

    // Behavioural model
    logic [15:0] q[$];
    logic        m_overflow;
    logic        m_in_full;
    logic [15:0] m_in_data;
    int          m_int_phase;  // 0 idle, 1 first code, 2 second code
    logic        m_pending;
    logic        m_req_prev;

    int pass_count = 0;
    int total_count = 0;

    function automatic logic [1:0] phase_code(int p);
        if (p == 1) return 2'b11;
        if (p == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic rise;
        logic popped;
        if (reset) begin
            q.delete();
            m_overflow = 0; m_in_full = 0; m_in_data = 0;
            m_int_phase = 0; m_pending = 0; m_req_prev = 0;
            return;
        end
        popped = (q.size() != 0) && dev_out_ready;
        if (popped) begin
            $display("t=%0t device took %h", $time, q[0]);
            void'(q.pop_front());
        end
        if (out_en) begin
            if (q.size() < 4) q.push_back(out_data);
            else m_overflow = 1;
        end
        if (!m_in_full && dev_in_valid) begin
            m_in_full = 1; m_in_data = dev_in_data;
        end else if (m_in_full && in_consume) begin
            m_in_full = 0;
        end
        rise = int_req && !m_req_prev;
        if (m_int_phase == 0) begin
            if (rise || m_pending) begin m_int_phase = 1; m_pending = 0; end
        end else begin
            if (rise) m_pending = 1;
            m_int_phase = (m_int_phase == 1) ? 2 : 0;
        end
        m_req_prev = int_req;
    endtask

    task automatic check_all();
        check("dev_out_valid", 32'(dev_out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("dev_out_data", 32'(dev_out_data), 32'(q[0]));
        check("dev_in_ready", 32'(dev_in_ready), 32'(!m_in_full));
        check("in_port_data", 32'(in_port_data), 32'(m_in_data));
        check("interrupt_signal", 32'(interrupt_signal), 32'(phase_code(m_int_phase)));
        check("overflow", 32'(overflow), 32'(m_overflow));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        out_en = 0; out_data = 0; dev_out_ready = 0;
        dev_in_valid = 0; dev_in_data = 0; in_consume = 0; int_req = 0;
    endtask

    task automatic do_reset();
        reset = 1; cycle(); reset = 0;
    endtask

    logic [1:0] int_seen [6];
    logic [1:0] int_want [6];

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        cycle(); cycle();
        reset = 0;
        check("reset_in_ready", 32'(dev_in_ready), 32'd1);

        // Latency of first OUT word, held while not ready
        out_en = 1; out_data = 16'h00A5; cycle();
        out_en = 0;
        check("lat_valid", 32'(dev_out_valid), 32'd1);
        check("lat_data", 32'(dev_out_data), 32'h00A5);
        repeat (3) cycle();
        dev_out_ready = 1; cycle(); dev_out_ready = 0;

        // Overflow: five words into a depth-4 FIFO, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            out_en = 1; out_data = 16'(i); cycle();
        end
        out_en = 0;
        check("ovf_set", 32'(overflow), 32'd1);
        dev_out_ready = 1;
        repeat (5) cycle();
        dev_out_ready = 0;
        check("ovf_drained", 32'(dev_out_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            out_en = 1; out_data = 16'(i); cycle();
        end
        out_en = 1; out_data = 16'd9; dev_out_ready = 1; cycle();
        out_en = 0; dev_out_ready = 0;
        check("pp_head", 32'(dev_out_data), 32'd2);
        check("pp_no_ovf", 32'(overflow), 32'd0);
        dev_out_ready = 1; repeat (5) cycle(); dev_out_ready = 0;

        // Empty FIFO with push and ready in the same cycle
        out_en = 1; out_data = 16'h0777; dev_out_ready = 1; cycle();
        out_en = 0;
        check("empty_pushpop", 32'(dev_out_data), 32'h0777);
        cycle(); dev_out_ready = 0;

        // Input holding register
        dev_in_valid = 1; dev_in_data = 16'h1234; cycle();
        check("in_capture", 32'(in_port_data), 32'h1234);
        dev_in_data = 16'h5678; repeat (2) cycle();
        check("in_blocked", 32'(in_port_data), 32'h1234);
        in_consume = 1; cycle(); in_consume = 0;
        check("in_hold_after_consume", 32'(in_port_data), 32'h1234);
        cycle();
        check("in_second", 32'(in_port_data), 32'h5678);
        dev_in_valid = 0; in_consume = 1; cycle(); in_consume = 0;

        // Interrupt: rise, drop, rise again during the sequence
        int_want[0] = 2'b11; int_want[1] = 2'b01; int_want[2] = 2'b00;
        int_want[3] = 2'b11; int_want[4] = 2'b01; int_want[5] = 2'b00;
        for (int i = 0; i < 6; i++) begin
            int_req = (i == 0 || i == 2);
            cycle();
            int_seen[i] = interrupt_signal;
        end
        int_req = 0;
        for (int i = 0; i < 6; i++) check($sformatf("int_seq%0d", i), 32'(int_seen[i]), 32'(int_want[i]));

        // Reset in the middle of an interrupt with three queued words
        do_reset();
        for (int i = 0; i < 3; i++) begin
            out_en = 1; out_data = 16'(16'h0100 + i); int_req = (i == 2); cycle();
        end
        out_en = 0; int_req = 0;
        check("mid_int_first", 32'(interrupt_signal), 32'h3);
        dev_in_valid = 1; dev_in_data = 16'hBEEF; dev_out_ready = 1;
        reset = 1; cycle(); reset = 0;
        idle_inputs();
        check("rst_int", 32'(interrupt_signal), 32'h0);
        check("rst_valid", 32'(dev_out_valid), 32'h0);
        check("rst_in_ready", 32'(dev_in_ready), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            out_en        = ($urandom_range(99) < 45);
            out_data      = 16'($urandom);
            dev_out_ready = ($urandom_range(99) < 40);
            dev_in_valid  = ($urandom_range(99) < 50);
            dev_in_data   = 16'($urandom);
            in_consume    = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 30) int_req = ~int_req;
            reset         = ($urandom_range(199) == 0);
            cycle();
        end
        reset = 0;
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
